ps2_receiver: RTL and testbench
===============================

# ps2_receiver

- Deserializes the PS/2 keyboard line (`ps2_clk`, `ps2_data`) into 8-bit scan-code bytes.
- Presents each byte on `ps2_byte` with a one-cycle `ps2_state` strobe.
- Sits directly upstream of `ps2_parser`, which consumes `ps2_byte`/`ps2_state` and maintains the `keys` vector.
- Handles input synchronization, clock-line glitch filtering, 11-bit frame checking and a mid-frame timeout.

## Interface
- `FILTER_LEN`, 4: consecutive identical synchronized samples required before the filtered `ps2_clk` level changes (2..15).
- `TIMEOUT_CYC`, 50000: `clk` cycles without a filtered falling edge, while mid-frame, before the frame is abandoned.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock from the pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the pin, asynchronous.
- `ps2_byte`  out  8  last good received byte; holds until the next good frame.
- `ps2_state`  out  1  one-cycle strobe: `ps2_byte` was updated this cycle.
- `frame_err`  out  1  one-cycle strobe: a frame was dropped (stop, parity or timeout).

## Operation
- Both raw inputs pass through a 2-FF synchronizer.
- **Clock filter:**
  - The synchronized `ps2_clk` feeds a filter whose output flips only after `FILTER_LEN` consecutive samples differ from its current level.
  - Reset level is 1.
  - Data is not filtered.
- A falling edge is the filtered clock going 1→0. Data is sampled from synchronized `ps2_data` on that cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - **IDLE:** on a falling edge with data=0 (start bit), clear the shift register and bit counter, then go to DATA. Data=1 is a glitch: stay in IDLE, no error.
  - **DATA:** each falling edge shifts data in LSB-first (shift right, new bit into [7]) and increments the 3-bit counter. After the 8th bit, go to PARITY.
  - **PARITY:** latch the parity bit, go to STOP.
  - **STOP:** on the falling edge:
    - If data=1 and the parity check passes: load `ps2_byte` from the shift register, pulse `ps2_state`.
    - Otherwise: pulse `frame_err`; `ps2_byte` is unchanged.
    - Return to IDLE in both cases.
- Parity is odd: XOR of the 8 data bits and the parity bit must equal 1.
- **Timeout counter:**
  - Cleared on every falling edge and while in IDLE; saturates.
  - Reaching `TIMEOUT_CYC` in any non-IDLE state forces IDLE and pulses `frame_err`. No byte is output.
- The block never drives the PS/2 lines (receive only; no host-to-device inhibit).

## Timing
- **Reset values:**
  - `ps2_byte` = 8'h00, `ps2_state` = 0, `frame_err` = 0.
  - FSM in IDLE, filter output 1, counters 0.
- Reset asserted mid-frame abandons the frame immediately with no `frame_err`. The first frame after release is received normally, provided its start edge occurs after release.
- **Latency:** from the raw stop-bit falling edge to `ps2_state` high is FILTER_LEN+3 `clk` edges (±1 for sampling phase).
  - 2 sync stages, FILTER_LEN filter samples, 1 registered output.
- `ps2_byte` changes on the same edge that `ps2_state` rises. It is stable for the whole strobe cycle and afterwards.
- `ps2_state` and `frame_err` are never high together. Each is high for exactly one cycle per frame.
- **Timeout vs. edge in the same cycle:** the falling edge wins; the counter clears and the frame continues.
- **Minimum clock requirement:** `clk` ≥ 2·(FILTER_LEN+2) × PS/2 clock rate. At 50 MHz and a 10–16.7 kHz PS/2 clock there is ample margin.
- **Back-to-back frames:** a start bit on the edge immediately following STOP is accepted. No idle gap is required beyond the return to IDLE.

## Configuration
- **`PS2_PARITY_CHECK_EN` defined:**
  - Failing odd parity drops the frame and pulses `frame_err`.
- **Not defined:**
  - The parity bit is still clocked through PARITY but ignored.
  - Only a bad stop bit or a timeout causes `frame_err`.

## Test plan
- **Byte 0x29 (space), parity 0, stop 1, at 12.5 kHz:**
  - `ps2_state` pulses once, `ps2_byte`=8'h29, `frame_err` stays 0.
- **Sequence 0xF0 (parity 1) then 0x1C (parity 0), back-to-back:**
  - Two strobes.
  - `ps2_byte`=8'hF0 after the first and 8'h1C after the second.
- **0x1C sent with parity 1:**
  - With `PS2_PARITY_CHECK_EN`: `frame_err` pulse, `ps2_byte` keeps its previous value.
  - Without the macro: strobe with 8'h1C.
- **0x29 sent with stop bit 0:**
  - `frame_err` pulses once, no `ps2_state`.
  - A following good 0x1C frame is received correctly.
- **Start, 4 data bits, then the line is held idle for TIMEOUT_CYC+10 cycles:**
  - One `frame_err`, FSM in IDLE.
  - The next full 0x29 frame yields `ps2_byte`=8'h29.
- **Robustness pulses:**
  - 1-cycle low glitches on `ps2_clk` (< FILTER_LEN) during a 0x29 frame: ignored, result 8'h29.
  - `rst_n` pulsed low mid-frame: all outputs 0, no strobe.

Source files
------------

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ps2_receiver
// Desc     : Receive-only PS/2 deserializer: sync, clock glitch filter, 11-bit
//            frame check, mid-frame timeout. Define PS2_PARITY_CHECK_EN to
//            drop frames that fail odd parity.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_receiver #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ps2_byte,
    output logic       ps2_state,
    output logic       frame_err
);

    localparam int                c_TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]        c_FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX    = c_TO_W'(TIMEOUT_CYC);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DATA   = 2'd1;
    localparam logic [1:0] c_PARITY = 2'd2;
    localparam logic [1:0] c_STOP   = 2'd3;

    logic [1:0]        r_clk_sync;
    logic [1:0]        r_data_sync;
    logic              r_filt;
    logic              r_filt_prev;
    logic [3:0]        r_filt_cnt;
    logic [1:0]        r_state;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit_cnt;
    logic [c_TO_W-1:0] r_timeout;
    logic [7:0]        r_byte;
    logic              r_ps2_state;
    logic              r_frame_err;
    logic              w_fall;
    logic              w_data;
    logic              w_parity_ok;

    // Sync flops reset to the idle (high) line level so a reset never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_filt      <= 1'b1;
            r_filt_prev <= 1'b1;
            r_filt_cnt  <= 4'd0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_filt_prev <= r_filt;
            if (r_clk_sync[1] != r_filt) begin
                if (r_filt_cnt == c_FILT_LAST) begin
                    r_filt     <= ~r_filt;
                    r_filt_cnt <= 4'd0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 4'd1;
                end
            end else begin
                r_filt_cnt <= 4'd0;
            end
        end
    end

    assign w_fall = r_filt_prev & ~r_filt;
    assign w_data = r_data_sync[1];

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_fall && r_state == c_PARITY) begin
            r_parity <= w_data;
        end
    end

    assign w_parity_ok = ^{r_shift, r_parity};
`else
    assign w_parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_shift     <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_timeout   <= '0;
            r_byte      <= 8'h00;
            r_ps2_state <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_ps2_state <= 1'b0;
            r_frame_err <= 1'b0;

            if (r_state == c_IDLE || w_fall) begin
                r_timeout <= '0;
            end else if (r_timeout != c_TO_MAX) begin
                r_timeout <= r_timeout + 1'b1;
            end

            // A falling edge in the same cycle as the timeout keeps the frame alive
            if (w_fall) begin
                case (r_state)
                    c_IDLE: begin
                        if (!w_data) begin
                            r_shift   <= 8'h00;
                            r_bit_cnt <= 3'd0;
                            r_state   <= c_DATA;
                        end
                    end
                    c_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_PARITY;
                        end
                    end
                    c_PARITY: begin
                        r_state <= c_STOP;
                    end
                    c_STOP: begin
                        if (w_data && w_parity_ok) begin
                            r_byte      <= r_shift;
                            r_ps2_state <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= c_IDLE;
                    end
                    default: r_state <= c_IDLE;
                endcase
            end else if (r_state != c_IDLE && r_timeout == c_TO_MAX) begin
                r_state     <= c_IDLE;
                r_frame_err <= 1'b1;
            end
        end
    end

    assign ps2_byte  = r_byte;
    assign ps2_state = r_ps2_state;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_receiver
// Desc     : Scoreboard bench for ps2_receiver: directed + random PS/2 frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_receiver;

    localparam int c_FILTER_LEN  = 4;
    localparam int c_TIMEOUT_CYC = 400;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ps2_byte;
    logic       ps2_state;
    logic       frame_err;

    int         n_checks;
    int         n_fail;
    exp_t       exp_q[$];
    logic [7:0] model_byte;

    ps2_receiver #(
        .FILTER_LEN  (c_FILTER_LEN),
        .TIMEOUT_CYC (c_TIMEOUT_CYC)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_byte  (ps2_byte),
        .ps2_state (ps2_state),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: a frame is good when the stop bit is 1 and, with checking on,
    // the nine data+parity bits hold an odd number of ones.
    function automatic exp_t model(input logic [7:0] d, input logic p, input logic s);
        exp_t e;
        bit   ok;
        ok = s;
`ifdef PS2_PARITY_CHECK_EN
        if ((($countones(d) + int'(p)) % 2) != 1) ok = 1'b0;
`endif
        e.err  = ~ok;
        e.data = d;
        return e;
    endfunction

    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, input int h, input bit glitch);
        int a;
        wait_cyc(2);
        ps2_data = b;
        if (glitch) begin
            a = (h - 2) / 2;
            wait_cyc(a);
            ps2_clk = 1'b0;
            wait_cyc(1);
            ps2_clk = 1'b1;
            wait_cyc(h - 3 - a);
        end else begin
            wait_cyc(h - 2);
        end
        ps2_clk = 1'b0;
        wait_cyc(h);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int h, input bit glitch, input int gap);
        exp_q.push_back(model(d, p, s));
        send_bit(1'b0, h, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], h, glitch && (i >= 2) && (i <= 5));
        send_bit(p, h, 1'b0);
        send_bit(s, h, 1'b0);
        ps2_data = 1'b1;
        if (gap > 0) wait_cyc(gap);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ps2_state && frame_err) begin
                n_checks++;
                n_fail++;
                $display("FAIL both_strobes actual=11 required=one_of");
            end else if (ps2_state || frame_err) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event actual=state%0b_err%0b required=none",
                             ps2_state, frame_err);
                end else begin
                    e = exp_q.pop_front();
                    if (e.err) begin
                        check("frame_err", {31'd0, frame_err}, 32'd1);
                        check("byte_held", {24'd0, ps2_byte}, {24'd0, model_byte});
                    end else begin
                        check("strobe", {31'd0, ps2_state}, 32'd1);
                        check("byte", {24'd0, ps2_byte}, {24'd0, e.data});
                        model_byte = e.data;
                    end
                end
            end
        end
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        model_byte = 8'h00;
        rst_n      = 1'b0;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        wait_cyc(5);
        check("rst_byte", {24'd0, ps2_byte}, 32'd0);
        check("rst_state", {31'd0, ps2_state}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(10);

        send_frame(8'h29, 1'b0, 1'b1, 20, 1'b0, 30);
        send_frame(8'hF0, 1'b1, 1'b1, 16, 1'b0, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 16, 1'b0, 30);
        send_frame(8'h1C, 1'b1, 1'b1, 12, 1'b0, 30);
        send_frame(8'h29, 1'b0, 1'b0, 12, 1'b0, 30);
        send_frame(8'h1C, 1'b0, 1'b1, 12, 1'b0, 30);

        // Abandoned frame: start plus four data bits, then silence
        exp_q.push_back('{err: 1'b1, data: 8'h00});
        send_bit(1'b0, 12, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 12, 1'b0);
        ps2_data = 1'b1;
        wait_cyc(c_TIMEOUT_CYC + 10);
        send_frame(8'h29, 1'b0, 1'b1, 12, 1'b0, 30);

        send_frame(8'h29, 1'b0, 1'b1, 20, 1'b1, 30);

        // Reset in the middle of a frame
        send_bit(1'b0, 12, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 12, 1'b0);
        ps2_clk = 1'b0;
        wait_cyc(3);
        rst_n = 1'b0;
        wait_cyc(2);
        check("midrst_byte", {24'd0, ps2_byte}, 32'd0);
        check("midrst_state", {31'd0, ps2_state}, 32'd0);
        check("midrst_err", {31'd0, frame_err}, 32'd0);
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        model_byte = 8'h00;
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(20);
        send_frame(8'h29, 1'b0, 1'b1, 12, 1'b0, 30);

        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            logic       p;
            logic       s;
            d = 8'($urandom_range(0, 255));
            p = odd_par(d);
            if ($urandom_range(0, 5) == 0) p = ~p;
            s = ($urandom_range(0, 5) != 0);
            send_frame(d, p, s, $urandom_range(8, 25), ($urandom_range(0, 3) == 0),
                       $urandom_range(0, 30));
        end

        wait_cyc(50);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
